// File: rtl/adc_frame_spi_tx_if.sv
// Sample stream from the AD7265 parallel-read stage: 12-bit code plus channel tag.
// One-cycle valid strobe, no backpressure.
interface adc_frame_spi_tx_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] s_data;
  logic [1:0]        s_chan;
  logic              s_valid;

  modport master (output s_data, output s_chan, output s_valid);
  modport slave  (input  s_data, input  s_chan, input  s_valid);
endinterface

// File: rtl/adc_frame_spi_tx.sv
// Buffers tagged ADC samples in a FIFO and ships them as CS-framed, MSB-first SPI
// frames (one word per channel) to the DSP McBSP acting as slave receiver.
module adc_frame_spi_tx #(
  parameter int CLK_DIV         = 2,
  parameter int WORDS_PER_FRAME = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int GAP_CYC         = 4,
  parameter int DATA_W          = 12
) (
  input  logic                          clkin,
  input  logic                          rst,
  adc_frame_spi_tx_if.slave             s_if,
  output logic                          sclk,
  output logic                          spi_cs,
  output logic                          mosi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          ovf,
  output logic                          sync_err
);

  localparam int ENTRY_W    = DATA_W + 2;
  localparam int WORD_W     = DATA_W + 4;
  localparam int FRAME_BITS = WORD_W * WORDS_PER_FRAME;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int WB_W       = $clog2(WORD_W);

  typedef enum logic [2:0] {IDLE, HEAD, SHIFT, TAIL, GAP} state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_q;
  logic                 full, push, pop;
  logic [ENTRY_W-1:0]   head;
  logic [1:0]           head_chan;
  logic [WORD_W-1:0]    head_word;
  logic [WORD_W-1:0]    sh_word;
  logic                 sh_load, sh_shift;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 tick, last_bit, word_end;
  logic                 sclk_d, cs_d, mosi_d, done_d, sync_set;

  // Serial word layout: two zero pad bits, channel tag, then the ADC code.
  function automatic logic [WORD_W-1:0] fmt_word(input logic [ENTRY_W-1:0] e);
    return {2'b00, e};
  endfunction

  assign head       = mem[rd_ptr];
  assign head_chan  = head[ENTRY_W-1 -: 2];
  assign head_word  = fmt_word(head);
  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign push       = s_if.s_valid && (!full || pop);
  assign fifo_level = level_q;
  assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit   = (bit_q == BIT_W'(FRAME_BITS - 1));
  assign word_end   = &bit_q[WB_W-1:0];

  // ---- FIFO: a pop frees the slot a same-cycle push may land in when full
  always_ff @(posedge clkin) begin
    if (push) mem[wr_ptr] <= {s_if.s_chan, s_if.s_data};
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (s_if.s_valid && !push) ovf <= 1'b1;
    end
  end

  // ---- Frame FSM: state register
  always_ff @(posedge clkin) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q >= LW'(WORDS_PER_FRAME)) state_d = HEAD;
      HEAD:    state_d = (head_chan != 2'd0) ? IDLE : SHIFT;
      SHIFT:   if (tick && !sclk && last_bit) state_d = TAIL;
      TAIL:    if (tick) state_d = GAP;
      GAP:     if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mosi changes only on falling sclk; the word pointer advances on rising sclk,
  // so the DSP always samples a bit that has been stable for a half period.
  always_comb begin
    pop      = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sync_set = 1'b0;
    done_d   = 1'b0;
    sclk_d   = sclk;
    cs_d     = spi_cs;
    mosi_d   = mosi;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        gap_d  = '0;
        sclk_d = 1'b1;
        cs_d   = 1'b1;
        mosi_d = 1'b0;
      end
      HEAD: begin
        pop   = 1'b1;
        div_d = '0;
        bit_d = '0;
        if (head_chan != 2'd0) begin
          sync_set = 1'b1;
        end else begin
          sh_load = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = head_word[WORD_W-1];
        end
      end
      SHIFT: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk;
          if (sclk) begin
            mosi_d = sh_word[WORD_W-1];
          end else if (!last_bit) begin
            bit_d = bit_q + 1'b1;
            if (word_end) begin
              pop     = 1'b1;
              sh_load = 1'b1;
            end else begin
              sh_shift = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      TAIL: begin
        if (tick) begin
          div_d  = '0;
          cs_d   = 1'b1;
          mosi_d = 1'b0;
          done_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
      end
      default: ;
    endcase
  end

  // ---- Output / counter registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      sclk       <= 1'b1;
      spi_cs     <= 1'b1;
      mosi       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
    end else begin
      sclk       <= sclk_d;
      spi_cs     <= cs_d;
      mosi       <= mosi_d;
      frame_done <= done_d;
      sync_err   <= sync_err | sync_set;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
    end
  end

  always_ff @(posedge clkin) begin
    if (sh_load)       sh_word <= head_word;
    else if (sh_shift) sh_word <= {sh_word[WORD_W-2:0], 1'b0};
  end

endmodule

// File: doc/adc_frame_spi_tx.md
Name: adc_frame_spi_tx

Overview:
- Downstream stage of the AD7265 parallel-read controller.
- Accepts 12-bit samples with a 2-bit channel tag, buffers them in a small FIFO, and groups 4 channels into one frame.
- Shifts each frame out MSB-first over a CS-framed SPI link to the VC5509A McBSP (DSP acts as slave receiver).
- Decouples bursty ADC reads from the fixed serial bit rate.

Parameters:
- CLK_DIV, 2, sclk half-period in clkin cycles (≥1); bit period = 2*CLK_DIV.
- WORDS_PER_FRAME, 4, words per CS-low frame (one per AD7265 channel).
- FIFO_DEPTH, 8, FIFO entries; power of 2, ≥ WORDS_PER_FRAME.
- GAP_CYC, 4, minimum clkin cycles spi_cs stays high between frames.

Ports:
- clkin  in  1  system clock, 24 MHz.
- rst  in  1  synchronous reset, active-high.
- s_data  in  12  sample from the parallel-read stage.
- s_chan  in  2  channel index of s_data (0..3).
- s_valid  in  1  one-cycle strobe, s_data/s_chan valid; no backpressure.
- sclk  out  1  SPI clock, idle high.
- spi_cs  out  1  frame select, active-low.
- mosi  out  1  serial data.
- fifo_level  out  4  current FIFO occupancy (0..FIFO_DEPTH).
- frame_done  out  1  one-cycle pulse on the cycle spi_cs returns high.
- ovf  out  1  sticky: sample dropped because FIFO full.
- sync_err  out  1  sticky: frame head was not channel 0.

Behaviour:
- Reset (sync, rst=1 at posedge clkin): sclk=1, spi_cs=1, mosi=0, frame_done=0, ovf=0, sync_err=0, FIFO emptied, fifo_level=0, FSM=IDLE. Applies mid-frame: frame is aborted immediately, no frame_done.
- FIFO entry = {s_chan, s_data} (14 bits).
- Push: when s_valid=1 and FIFO not full.
- s_valid while full with no pop in the same cycle: sample dropped, ovf←1.
- Push and pop in the same cycle (including when full) are both accepted; level unchanged.
- fifo_level is registered and updates the cycle after push/pop.
- Serial word = 16 bits {2'b00, chan[1:0], data[11:0]}, MSB first. Frame = WORDS_PER_FRAME words = 64 bits by default.
- FSM states: IDLE, HEAD, SHIFT, TAIL, GAP.
- IDLE → HEAD when fifo_level ≥ WORDS_PER_FRAME.
- HEAD (1 cycle): inspect FIFO head chan.
  - chan≠0: pop and discard it, sync_err←1, return to IDLE. Realigns the stream to channel 0.
  - chan=0: pop into shift register, spi_cs←0, mosi←bit15, sclk stays 1; go to SHIFT. This cycle is t=0.
- SHIFT: sclk toggles every CLK_DIV cycles.
  - sclk falls at t=(2k+1)*CLK_DIV; for k≥1, mosi updates to frame bit k on that fall.
  - sclk rises at t=(2k+2)*CLK_DIV; the DSP samples on this edge.
  - At each 16-bit word boundary, the next word is popped on the cycle the last bit of the prior word rises. Its chan is not checked.
- TAIL: after the rising edge of the last bit (t=2*64*CLK_DIV), hold CLK_DIV cycles with sclk=1, then spi_cs←1, mosi←0, frame_done=1 for one cycle.
  - spi_cs low duration = 129*CLK_DIV cycles (258 at default).
- GAP: spi_cs held high GAP_CYC cycles, then IDLE. Frames may start back-to-back after the gap.
- Pushes continue during any state; the shifter never reads an empty FIFO because the frame starts only with ≥ WORDS_PER_FRAME entries.
- Counters: bit counter 0..63 and divider 0..CLK_DIV-1, both reset to 0 in IDLE.

Test Plan:
- Reset, then push chans 0,1,2,3 with data 0xABC,0x123,0x456,0x789 → spi_cs low 258 cycles; mosi stream 0x0ABC,0x1123,0x2456,0x3789; 64 sclk rising edges; frame_done single pulse; fifo_level returns to 0.
- Push chan 2,3 then 0,1,2,3 → two HEAD discards, sync_err=1, then one correct frame starting with 0x0ABC-style chan-0 word; ovf stays 0.
- Push 10 samples with no frame drain possible (hold in GAP via continuous pushes at 1/cycle) → fifo_level saturates at 8, ovf=1; push+pop on the same cycle at full does not set ovf.
- Assert rst for 1 cycle at mid-frame bit 30 → next cycle spi_cs=1, sclk=1, mosi=0, fifo_level=0, flags cleared, no frame_done.
- 8 valid samples pushed back-to-back (two frames) → two frames separated by spi_cs high ≥4 cycles, two frame_done pulses, data order preserved.
- CLK_DIV=1 build → sclk period 2 cycles, spi_cs low 129 cycles, same bit stream.
